// File: rtl/pattern_pkg.sv
// Definitions shared by the serial pattern detector and its match event reporter.
package pattern_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_COUNT = ST_COUNT
  } rep_state_t;

  // Detector state codes live here so both stages agree on one encoding.
  typedef enum logic [1:0] {
    DET_A = 2'd0,
    DET_B = 2'd1,
    DET_C = 2'd2
  } det_state_t;

endpackage

// File: rtl/window_timer.sv
// Free-running window timer: counts 0..WINDOW_CYCLES-1 while run is high and
// flags the final cycle of each window with win_end.
module window_timer #(
  parameter int WIN_W         = 16,
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic run,
  output logic win_end
);

  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0] timer_q;

  assign win_end = run && (timer_q == LAST);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      timer_q <= '0;
    end else if (run) begin
      timer_q <= (timer_q == LAST) ? '0 : timer_q + 1'b1;
    end
  end

endmodule

// File: rtl/match_event_reporter.sv
// Counts detector match pulses per fixed window and publishes each window's
// count through a one-entry valid/ready register; unacceptable reports are dropped.
module match_event_reporter
  import pattern_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int WIN_W         = 16,
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             EVT_IN,
  output logic [CNT_W-1:0] CNT_OUT,
  output logic             CNT_SAT,
  output logic             CNT_VALID,
  input  logic             CNT_READY,
  output logic             OVERRUN
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rep_state_t       state_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             acc_sat_q, acc_sat_d;
  logic [CNT_W-1:0] cnt_out_q;
  logic             cnt_sat_q, valid_q, overrun_q;
  logic             counting, win_end, slot_free, load;

  assign counting  = (state_q == S_COUNT) && ENABLE;
  assign slot_free = !valid_q || CNT_READY;
  assign load      = win_end && slot_free;

  window_timer #(
    .WIN_W        (WIN_W),
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (!counting),
    .run    (counting),
    .win_end(win_end)
  );

  // Saturating sum including this cycle's event; doubles as the window-end value.
  always_comb begin
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    if (EVT_IN) begin
      if (acc_q == CNT_MAX) begin
        acc_sat_d = 1'b1;
      end else begin
        acc_d = acc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      cnt_out_q <= '0;
      cnt_sat_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= win_end && !slot_free;

      if (load) begin
        cnt_out_q <= acc_d;
        cnt_sat_q <= acc_sat_d;
        valid_q   <= 1'b1;
      end else if (valid_q && CNT_READY) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          acc_q     <= '0;
          acc_sat_q <= 1'b0;
          if (ENABLE) state_q <= S_COUNT;
        end
        S_COUNT: begin
          if (!ENABLE || win_end) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            if (!ENABLE) state_q <= S_IDLE;
          end else begin
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CNT_OUT   = cnt_out_q;
  assign CNT_SAT   = cnt_sat_q;
  assign CNT_VALID = valid_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_match_event_reporter.sv
// Bench for match_event_reporter: directed scenarios plus random traffic, all
// checked against a window-level behavioural model.
module tb_match_event_reporter;
  import pattern_pkg::*;

  localparam int CNT_W = 3;
  localparam int WIN_W = 16;
  localparam int WIN   = 8;
  localparam int CMAX  = 7;

  logic             CLK = 1'b0;
  logic             RST, ENABLE, EVT_IN, CNT_READY;
  logic [CNT_W-1:0] CNT_OUT;
  logic             CNT_SAT, CNT_VALID, OVERRUN;

  int errors = 0;
  int checks = 0;

  // Model: position in window (-1 = idle), events seen so far, report slot.
  int         m_phase;
  int         m_events;
  logic       m_valid, m_sat, m_ovr;
  logic [2:0] m_out;

  wire [5:0] obs  = {CNT_VALID, CNT_OUT, CNT_SAT, OVERRUN};
  wire [5:0] mexp = {m_valid, m_out, m_sat, m_ovr};

  match_event_reporter #(
    .CNT_W(CNT_W), .WIN_W(WIN_W), .WINDOW_CYCLES(WIN)
  ) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .EVT_IN(EVT_IN),
    .CNT_OUT(CNT_OUT), .CNT_SAT(CNT_SAT), .CNT_VALID(CNT_VALID),
    .CNT_READY(CNT_READY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, predict post-edge outputs, then advance past the edge.
  task automatic step(input logic rst, input logic en, input logic evt, input logic rdy);
    int n;
    RST = rst; ENABLE = en; EVT_IN = evt; CNT_READY = rdy;
    m_ovr = 1'b0;
    if (rst) begin
      m_phase = -1; m_events = 0; m_valid = 1'b0; m_out = '0; m_sat = 1'b0;
    end else if (m_phase < 0) begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (en) begin m_phase = 0; m_events = 0; end
    end else if (!en) begin
      if (m_valid && rdy) m_valid = 1'b0;
      m_phase = -1; m_events = 0;
    end else begin
      n = m_events + (evt ? 1 : 0);
      if (m_phase == WIN - 1) begin
        if (!m_valid || rdy) begin
          m_out   = 3'((n > CMAX) ? CMAX : n);
          m_sat   = (n > CMAX);
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        m_events = 0; m_phase = 0;
      end else begin
        m_events = n; m_phase++;
        if (m_valid && rdy) m_valid = 1'b0;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_outputs: got=%b exp=000000", obs); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (CNT_VALID !== 1'b0 || obs !== mexp) begin
        errors++; $display("FAIL idle_events cyc%0d: got=%b exp=%b", i, obs, mexp);
      end
    end
  endtask

  task automatic test_single_window();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int w = 0; w < WIN; w++) begin
      step(1'b0, 1'b1, (w == 1 || w == 4 || w == 7), 1'b1);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL window1 w%0d: got=%b exp=%b", w, obs, mexp); end
    end
    checks++;
    if (CNT_OUT !== 3'd3 || CNT_SAT !== 1'b0 || CNT_VALID !== 1'b1) begin
      errors++; $display("FAIL window1_report: got out=%0d sat=%b v=%b exp out=3 sat=0 v=1", CNT_OUT, CNT_SAT, CNT_VALID);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (CNT_VALID !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got=%b exp=0", CNT_VALID); end
  endtask

  task automatic test_saturation();
    for (int w = 1; w < WIN; w++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL sat_window w%0d: got=%b exp=%b", w, obs, mexp); end
    end
    checks++;
    if (CNT_OUT !== 3'd7 || CNT_SAT !== 1'b1 || CNT_VALID !== 1'b1) begin
      errors++; $display("FAIL sat_report: got out=%0d sat=%b v=%b exp out=7 sat=1 v=1", CNT_OUT, CNT_SAT, CNT_VALID);
    end
    for (int w = 0; w < WIN; w++) begin
      step(1'b0, 1'b1, (w == 2 || w == 5), 1'b1);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL post_sat w%0d: got=%b exp=%b", w, obs, mexp); end
    end
    checks++;
    if (CNT_OUT !== 3'd2 || CNT_SAT !== 1'b0 || CNT_VALID !== 1'b1) begin
      errors++; $display("FAIL sat_cleared: got out=%0d sat=%b v=%b exp out=2 sat=0 v=1", CNT_OUT, CNT_SAT, CNT_VALID);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (CNT_VALID !== 1'b0) begin errors++; $display("FAIL sat_consumed: got=%b exp=0", CNT_VALID); end
  endtask

  task automatic test_backpressure();
    logic [2:0] held;
    int         cnt;
    for (int w = 1; w < WIN; w++) begin
      step(1'b0, 1'b1, 1'($urandom % 2), 1'b0);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL bp_first w%0d: got=%b exp=%b", w, obs, mexp); end
    end
    held = m_out;
    for (int w = 0; w < WIN; w++) begin
      step(1'b0, 1'b1, 1'($urandom % 2), 1'b0);
      checks++;
      if (obs !== mexp || CNT_OUT !== held || CNT_VALID !== 1'b1) begin
        errors++; $display("FAIL bp_hold w%0d: got=%b exp=%b held=%0d", w, obs, mexp, held);
      end
    end
    checks++;
    if (OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got=%b exp=1", OVERRUN); end
    cnt = 0;
    for (int w = 0; w < WIN; w++) begin
      logic e;
      e = 1'($urandom % 2);
      cnt += e ? 1 : 0;
      step(1'b0, 1'b1, e, (w == WIN - 1));
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL bp_reload w%0d: got=%b exp=%b", w, obs, mexp); end
      if (w == 0) begin
        checks++;
        if (OVERRUN !== 1'b0 || CNT_OUT !== held) begin
          errors++; $display("FAIL overrun_one_cycle: got ovr=%b out=%0d exp ovr=0 out=%0d", OVERRUN, CNT_OUT, held);
        end
      end
    end
    checks++;
    if (CNT_VALID !== 1'b1 || CNT_OUT !== 3'(cnt) || OVERRUN !== 1'b0) begin
      errors++; $display("FAIL back_to_back: got v=%b out=%0d ovr=%b exp v=1 out=%0d ovr=0", CNT_VALID, CNT_OUT, OVERRUN, cnt);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (CNT_VALID !== 1'b0) begin errors++; $display("FAIL bp_drain: got=%b exp=0", CNT_VALID); end
  endtask

  task automatic test_disable();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int w = 0; w < 5; w++) begin
      step(1'b0, 1'b1, (w == 1 || w == 3), 1'b1);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL dis_part w%0d: got=%b exp=%b", w, obs, mexp); end
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'($urandom % 2), 1'b1);
      checks++;
      if (CNT_VALID !== 1'b0 || obs !== mexp) begin
        errors++; $display("FAIL dis_no_report cyc%0d: got=%b exp=%b", i, obs, mexp);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int w = 0; w < WIN; w++) begin
      step(1'b0, 1'b1, (w == 6), 1'b1);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL reenable w%0d: got=%b exp=%b", w, obs, mexp); end
    end
    checks++;
    if (CNT_OUT !== 3'd1 || CNT_SAT !== 1'b0 || CNT_VALID !== 1'b1) begin
      errors++; $display("FAIL reenable_report: got out=%0d sat=%b v=%b exp out=1 sat=0 v=1", CNT_OUT, CNT_SAT, CNT_VALID);
    end
    for (int w = 0; w < WIN - 1; w++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (CNT_VALID !== 1'b0 || OVERRUN !== 1'b0 || obs !== mexp) begin
      errors++; $display("FAIL disable_at_end: got=%b exp=%b", obs, mexp);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < WIN + 3; w++) step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (CNT_VALID !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got=%b exp=1", CNT_VALID); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 6'b0 || dut.state_q !== S_IDLE) begin
      errors++; $display("FAIL reset_mid: got=%b st=%b exp=000000 st=%b", obs, dut.state_q, S_IDLE);
    end
  endtask

  task automatic test_random();
    int p;
    p = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        case ($urandom % 3)
          0: p = 10;
          1: p = 50;
          default: p = 90;
        endcase
      end
      step(($urandom % 200) == 0, ($urandom % 20) != 0, ($urandom % 100) < p, ($urandom % 10) < 6);
      checks++;
      if (obs !== mexp) begin errors++; $display("FAIL random cyc%0d: got=%b exp=%b", i, obs, mexp); end
    end
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b0; EVT_IN = 1'b0; CNT_READY = 1'b0;
    test_reset();
    test_single_window();
    test_saturation();
    test_backpressure();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
